// File: rtl/core_pkg.sv
// ============================================================================
//  Module      : core_pkg
//  Description : Shared RV32I core types: ALU opcodes, XLEN, ALU response.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    localparam int XLEN         = 32;
    localparam int C_ALU_TAG_W  = 4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef struct packed {
        logic [XLEN-1:0]        data;
        logic                   id;
        logic [C_ALU_TAG_W-1:0] tag;
    } alu_rsp_t;

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
//  Module      : alu
//  Description : RV32I combinational ALU; unknown opcodes produce zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
    import core_pkg::*;
(
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic [XLEN-1:0] alu_data
);

    logic [4:0] w_shamt;
    logic       w_lt_signed;
    logic       w_lt_unsigned;

    assign w_shamt       = operand_b[4:0];
    assign w_lt_signed   = $signed(operand_a) < $signed(operand_b);
    assign w_lt_unsigned = operand_a < operand_b;

    always_comb begin
        alu_data = '0;
        case (alu_op_t'(alu_op))
            ALU_ADD:  alu_data = operand_a + operand_b;
            ALU_SUB:  alu_data = operand_a - operand_b;
            ALU_SLL:  alu_data = operand_a << w_shamt;
            ALU_SLT:  alu_data = {{(XLEN-1){1'b0}}, w_lt_signed};
            ALU_SLTU: alu_data = {{(XLEN-1){1'b0}}, w_lt_unsigned};
            ALU_XOR:  alu_data = operand_a ^ operand_b;
            ALU_SRL:  alu_data = operand_a >> w_shamt;
            ALU_SRA:  alu_data = $unsigned($signed(operand_a) >>> w_shamt);
            ALU_OR:   alu_data = operand_a | operand_b;
            ALU_AND:  alu_data = operand_a & operand_b;
            default:  alu_data = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rsp_fifo2.sv
// ============================================================================
//  Module      : rsp_fifo2
//  Description : Two-entry synchronous FIFO with push/pop and occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rsp_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [0:1];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;

    // Storage is cleared on reset so the head reads zero until first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin sharing of one ALU between two valid/ready ports,
//                results queued in issue order in a 2-entry response FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter
    import core_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][3:0]       req_op,
    input  logic [1:0][XLEN-1:0]  req_a,
    input  logic [1:0][XLEN-1:0]  req_b,
    input  logic [1:0][TAG_W-1:0] req_tag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [XLEN-1:0]       rsp_data,
    output logic                  rsp_id,
    output logic [TAG_W-1:0]      rsp_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic             id;
        logic [TAG_W-1:0] tag;
    } rsp_entry_t;

    localparam int C_ENTRY_W = $bits(rsp_entry_t);

    logic             r_rr_ptr;
    logic [1:0]       w_grant;
    logic             w_sel;
    logic             w_can_issue;
    logic             w_fire;
    logic             w_pop;
    logic [1:0]       w_count;
    logic [XLEN-1:0]  w_alu_data;
    rsp_entry_t       w_push_entry;
    rsp_entry_t       w_head;

    // A lone requester always wins; under contention the pointer decides.
    always_comb begin
        w_grant = req_valid;
        if (req_valid == 2'b11) begin
            w_grant = r_rr_ptr ? 2'b10 : 2'b01;
        end
    end

    assign w_sel       = w_grant[1];
    assign w_pop       = rsp_valid & rsp_ready;
    assign w_can_issue = (w_count < 2'd2) | ((w_count == 2'd2) & w_pop);
    assign req_ready   = rst ? 2'b00 : (w_grant & {2{w_can_issue}});
    assign w_fire      = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_fire) begin
            r_rr_ptr <= ~w_sel;
        end
    end

    alu u_alu (
        .alu_op    (req_op[w_sel]),
        .operand_a (req_a[w_sel]),
        .operand_b (req_b[w_sel]),
        .alu_data  (w_alu_data)
    );

    assign w_push_entry.data = w_alu_data;
    assign w_push_entry.id   = w_sel;
    assign w_push_entry.tag  = req_tag[w_sel];

    rsp_fifo2 #(
        .WIDTH (C_ENTRY_W)
    ) u_rsp_fifo2 (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_fire),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (rsp_valid),
        .o_count     (w_count)
    );

    assign rsp_data = w_head.data;
    assign rsp_id   = w_head.id;
    assign rsp_tag  = w_head.tag;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Directed self-checking bench for alu_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][3:0]  req_op;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0][3:0]  req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_id;
    logic [3:0]       rsp_tag;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    typedef struct {
        logic [31:0] data;
        logic        id;
        logic [3:0]  tag;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd5,
                           OP_SRA = 4'd7, OP_OR = 4'd8, OP_AND = 4'd9;

    alu_arbiter #(.TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_tag   (rsp_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] tag);
        req_op[p]  = op;
        req_a[p]   = a;
        req_b[p]   = b;
        req_tag[p] = tag;
    endtask

    task automatic chk_head(input string name, input logic [31:0] data,
                            input logic id, input logic [3:0] tag);
        chk({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({name, "_data"},  rsp_data, data);
        chk({name, "_id"},    {31'd0, rsp_id}, {31'd0, id});
        chk({name, "_tag"},   {28'd0, rsp_tag}, {28'd0, tag});
    endtask

    initial begin
        int   idx[2];
        int   issued;
        int   recv;
        exp_t e;
        exp_t got;

        rst       = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        tick();
        tick();
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data",  rsp_data, 32'd0);
        chk("rst_rsp_id",    {31'd0, rsp_id}, 32'd0);
        chk("rst_rsp_tag",   {28'd0, rsp_tag}, 32'd0);
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);

        // Sustained contention: grants alternate 0,1,0,1
        rst = 1'b0;
        set_req(0, OP_SUB, 32'h10, 32'h01, 4'd2);
        set_req(1, OP_XOR, 32'hFF, 32'h0F, 4'd3);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("cont_ready%0d", i), {30'd0, req_ready},
                (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            if (i % 2 == 0) chk_head($sformatf("cont_head%0d", i), 32'h0000000F, 1'b0, 4'd2);
            else            chk_head($sformatf("cont_head%0d", i), 32'h000000F0, 1'b1, 4'd3);
        end
        req_valid = 2'b00;
        tick();
        chk("drain1_valid", {31'd0, rsp_valid}, 32'd0);

        // Single port ADD
        set_req(0, OP_ADD, 32'h5, 32'h3, 4'd1);
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        #1;
        chk("single_ready", {30'd0, req_ready}, 32'd1);
        tick();
        chk_head("single", 32'h8, 1'b0, 4'd1);
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        tick();
        chk("drain2_valid", {31'd0, rsp_valid}, 32'd0);

        // Backpressure from port 1
        rsp_ready = 1'b0;
        req_valid = 2'b10;
        for (int k = 0; k < 3; k++) begin
            set_req(1, OP_ADD, 32'(k + 1), 32'(k + 1), 4'(4 + k));
            #1;
            chk($sformatf("bp_ready%0d", k), {30'd0, req_ready}, (k < 2) ? 32'd2 : 32'd0);
            tick();
        end
        chk_head("bp_hold", 32'h2, 1'b1, 4'd4);
        chk("bp_full_ready", {30'd0, req_ready}, 32'd0);
        rsp_ready = 1'b1;
        #1;
        chk("bp_pop_push_ready", {30'd0, req_ready}, 32'd2);
        tick();
        chk_head("bp_after_pop", 32'h4, 1'b1, 4'd5);
        rsp_ready = 1'b0;
        set_req(1, OP_ADD, 32'h9, 32'h9, 4'd9);
        #1;
        chk("bp_still_full", {30'd0, req_ready}, 32'd0);
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        tick();
        chk_head("bp_third", 32'h6, 1'b1, 4'd6);
        tick();
        chk("drain3_valid", {31'd0, rsp_valid}, 32'd0);

        // Ordering and pointer wrap with random backpressure
        idx[0] = 0;
        idx[1] = 0;
        issued = 0;
        recv   = 0;
        for (int cyc = 0; cyc < 300 && recv < 6; cyc++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            for (int p = 0; p < 2; p++) begin
                req_valid[p] = (idx[p] < 3);
                set_req(p, OP_ADD, 32'h100 * (p + 1) + 32'(idx[p]),
                        32'h1000_0000 + 32'(idx[p] * 3), 4'(p * 8 + idx[p]));
            end
            #1;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("order_extra_rsp", 32'd1, 32'd0);
                end else begin
                    got = exp_q.pop_front();
                    chk($sformatf("order%0d_data", recv), rsp_data, got.data);
                    chk($sformatf("order%0d_id", recv), {31'd0, rsp_id}, {31'd0, got.id});
                    chk($sformatf("order%0d_tag", recv), {28'd0, rsp_tag}, {28'd0, got.tag});
                end
                recv++;
            end
            for (int p = 0; p < 2; p++) begin
                if (req_valid[p] && req_ready[p]) begin
                    e.data = req_a[p] + req_b[p];
                    e.id   = p[0];
                    e.tag  = req_tag[p];
                    exp_q.push_back(e);
                    idx[p]++;
                    issued++;
                end
            end
            tick();
        end
        req_valid = 2'b00;
        chk("order_issued", 32'(issued), 32'd6);
        chk("order_received", 32'(recv), 32'd6);
        chk("order_empty", {31'd0, rsp_valid}, 32'd0);

        // Reset mid-flight with a full FIFO and rr_ptr pointing at port 1
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        set_req(0, OP_ADD, 32'h1, 32'h1, 4'd1);
        tick();
        set_req(0, OP_ADD, 32'h2, 32'h2, 4'd2);
        tick();
        chk("mid_full_ready", {30'd0, req_ready}, 32'd0);
        rst = 1'b1;
        req_valid = 2'b00;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_data", rsp_data, 32'd0);
        set_req(0, OP_AND, 32'h0000F0F0, 32'h0000FF00, 4'd3);
        set_req(1, OP_OR,  32'h00000001, 32'h00000002, 4'd8);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        chk("post_rst_grant", {30'd0, req_ready}, 32'd1);
        tick();
        chk_head("post_rst", 32'h0000F000, 1'b0, 4'd3);

        // Arithmetic shift sign fill
        req_valid = 2'b10;
        set_req(1, OP_SRA, 32'h80000000, 32'h0000001F, 4'd7);
        #1;
        chk("sra_ready", {30'd0, req_ready}, 32'd2);
        tick();
        chk_head("sra", 32'hFFFFFFFF, 1'b1, 4'd7);
        req_valid = 2'b00;
        tick();
        chk("final_empty", {31'd0, rsp_valid}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
